systolic_out_collector: RTL and testbench
=========================================

Name: systolic_out_collector

Overview:
- Receiving end of the systolic array's bottom edge.
- Captures the per-column partial-sum outputs and their valids, which arrive skewed by one cycle per column (column j lags column 1 by j-1 cycles), and de-skews them into aligned rows.
- Aligned rows are buffered in a small FIFO and handed to the unified-buffer write path over a valid/ready handshake.
- Counts rows against a programmed row count and pulses done when the last row has left the FIFO.

Parameters:
SYSTOLIC_ARRAY_WIDTH, 4, number of columns; the port list below is fixed for 4.
FIFO_DEPTH, 4, aligned-row FIFO entries; must be a power of 2, at least 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
sys_data_out_41..sys_data_out_44  in  16 each  bottom-row psums, column 1..4
sys_valid_out_41..sys_valid_out_44  in  1 each  bottom-row valids, column 1..4
ub_rd_col_size_in  in  16  active column count
ub_rd_col_size_valid_in  in  1  loads the column mask
ub_wr_row_count_in  in  16  rows expected for this tile
ub_wr_row_count_valid_in  in  1  arms collection
col_data_out  out  64  aligned row; bits [15:0] are column 1, [63:48] are column 4
col_mask_out  out  4  enabled-column mask for col_data_out
col_valid_out  out  1  FIFO head valid
col_ready_in  in  1  consumer accepts head
col_busy  out  1  high in COLLECT or DRAIN
col_done  out  1  one-cycle pulse at tile completion
col_overflow  out  1  sticky: aligned row dropped because the FIFO was full
col_proto_err  out  1  sticky: misaligned or unexpected row

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - All outputs are 0; state is IDLE; FIFO is empty; the mask is 0; all delay-line valids are cleared.
  - Reset mid-tile discards everything in flight.
- Column mask:
  - On ub_rd_col_size_valid_in, mask <= (1<<min(size,4))-1. A size of 0 gives mask 0.
  - A load is honoured in any state and takes effect the next cycle.
- De-skew:
  - Every column input is registered once (capture stage).
  - Column j then passes through 4-j further delay registers carrying both data and valid. Columns 1/2/3/4 get 3/2/1/0 extra delay.
  - A row whose column-1 valid is seen at cycle c (column 4 at c+3) is aligned during cycle c+4.
- Row completion, evaluated each cycle on the aligned valids v[3:0]:
  - (v & mask) == mask and mask != 0: the row is complete. Disabled columns are zero-filled.
  - (v & mask) nonzero but != mask: misalignment. Set col_proto_err and drop the row.
  - v bits outside the mask are ignored.
- FSM:
  - IDLE:
    - ub_wr_row_count_valid_in with count N>0: load remaining=N and go to COLLECT.
    - N=0: pulse col_done the next cycle and stay in IDLE.
    - A completed row arriving in IDLE sets col_proto_err and is discarded.
  - COLLECT:
    - Each complete row is pushed into the FIFO (with col_mask_out = mask) and remaining decrements.
    - If the FIFO is full and no pop happens that cycle, the row is dropped, col_overflow is set, and remaining still decrements.
    - When remaining reaches 0, go to DRAIN.
    - Arm requests in COLLECT are ignored.
    - Complete rows beyond N that arrive after the move to DRAIN are treated as unexpected (col_proto_err).
  - DRAIN:
    - When the FIFO is empty, pulse col_done for one cycle and go to IDLE.
    - Arm requests in DRAIN are ignored.
- FIFO:
  - Registered storage, first-word fall-through.
  - The row pushed at the end of aligned cycle c+4 drives col_valid_out=1 at c+5 if the FIFO was empty.
  - Latency is therefore 5 cycles from the column-1 valid and 2 cycles from the column-4 valid.
  - Pop occurs when col_valid_out && col_ready_in.
  - Simultaneous push and pop is legal, including when full (occupancy unchanged) and when empty (the new row appears the next cycle).
  - col_data_out and col_mask_out hold stable while col_valid_out=1 and col_ready_in=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags clear only on rst.

Test Plan:
- mask=4'b1111, N=4; drive 4 rows skewed (column j valid at cycles c+r+j-1, row r value 16'h0r0j); col_ready_in=1 -> col_valid_out at c+5..c+8, row r = {0r04,0r03,0r02,0r01}; col_done pulse 1 cycle after the last pop; col_busy falls at the same time; no flags set.
- col_size=2, N=2, columns 3/4 valid held 0 -> rows output with [63:32]=0 and col_mask_out=4'b0011; done asserted.
- FIFO_DEPTH=4, N=6, col_ready_in=0 throughout collection -> 4 rows held, rows 5-6 dropped, col_overflow=1; after col_ready_in=1, exactly 4 rows pop, then col_done.
- Column 3 valid delayed one extra cycle on row 0 -> col_proto_err=1, row 0 dropped; rows 1-3 (N=4) are accepted, so remaining does not reach 0 and the FSM stays in COLLECT until a 4th good row arrives.
- A complete row while in IDLE, then arming with N=0 -> col_proto_err=1; col_done pulses the cycle after the arm; FIFO stays empty.
- rst for 1 cycle with 2 rows in the FIFO and 2 in the delay lines -> next cycle all outputs are 0, FIFO is empty, nothing emerges from the delay lines; a fresh N=1 tile completes normally.

Source files
------------

// File: rtl/systolic_out_collector.sv
// Bottom-edge collector for the systolic array: de-skews per-column psums into
// aligned rows, buffers them in a FWFT FIFO and tracks tile completion.
module systolic_out_collector #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 4,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sys_data_out_41,
  input  logic [15:0] sys_data_out_42,
  input  logic [15:0] sys_data_out_43,
  input  logic [15:0] sys_data_out_44,
  input  logic        sys_valid_out_41,
  input  logic        sys_valid_out_42,
  input  logic        sys_valid_out_43,
  input  logic        sys_valid_out_44,
  input  logic [15:0] ub_rd_col_size_in,
  input  logic        ub_rd_col_size_valid_in,
  input  logic [15:0] ub_wr_row_count_in,
  input  logic        ub_wr_row_count_valid_in,
  output logic [63:0] col_data_out,
  output logic [3:0]  col_mask_out,
  output logic        col_valid_out,
  input  logic        col_ready_in,
  output logic        col_busy,
  output logic        col_done,
  output logic        col_overflow,
  output logic        col_proto_err
);
  localparam int NC = SYSTOLIC_ARRAY_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  logic [15:0]      w_in_data  [NC];
  logic [NC-1:0]    w_in_valid;
  logic [15:0]      w_al_data  [NC];
  logic [NC-1:0]    w_al_valid;
  logic [NC-1:0]    r_mask;
  logic [NC-1:0]    w_mask_load;
  logic [NC-1:0]    w_vm;
  logic             w_complete;
  logic             w_misalign;
  logic [NC*16-1:0] w_row_data;

  logic [NC*16-1:0] r_mem_data [FIFO_DEPTH];
  logic [NC-1:0]    r_mem_mask [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  state_t           r_state;
  logic [15:0]      r_remaining;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;
  logic             r_proto_err;

  assign w_in_data[0]  = sys_data_out_41;
  assign w_in_data[1]  = sys_data_out_42;
  assign w_in_data[2]  = sys_data_out_43;
  assign w_in_data[3]  = sys_data_out_44;
  assign w_in_valid    = {sys_valid_out_44, sys_valid_out_43, sys_valid_out_42, sys_valid_out_41};

  // Column k sees one capture register plus NC-1-k alignment registers, so the
  // earliest column waits longest and all columns line up on the same cycle.
  for (genvar k = 0; k < NC; k++) begin : g_col
    localparam int D = NC - k;
    logic [15:0]  r_sh_data [D];
    logic [D-1:0] r_sh_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sh_valid <= '0;
        for (int s = 0; s < D; s++) r_sh_data[s] <= '0;
      end else begin
        r_sh_data[0]  <= w_in_data[k];
        r_sh_valid[0] <= w_in_valid[k];
        for (int s = 1; s < D; s++) begin
          r_sh_data[s]  <= r_sh_data[s-1];
          r_sh_valid[s] <= r_sh_valid[s-1];
        end
      end
    end

    assign w_al_data[k]  = r_sh_data[D-1];
    assign w_al_valid[k] = r_sh_valid[D-1];
  end

  // A size at or above NC enables every column.
  always_comb begin
    w_mask_load = '0;
    for (int i = 0; i < NC; i++) begin
      if (16'(i) < ub_rd_col_size_in) w_mask_load[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (ub_rd_col_size_valid_in) begin
      r_mask <= w_mask_load;
    end
  end

  assign w_vm       = w_al_valid & r_mask;
  assign w_complete = (r_mask != '0) && (w_vm == r_mask);
  assign w_misalign = (w_vm != '0) && (w_vm != r_mask);

  always_comb begin
    w_row_data = '0;
    for (int k = 0; k < NC; k++) begin
      if (r_mask[k]) w_row_data[16*k +: 16] = w_al_data[k];
    end
  end

  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_pop       = (r_count != '0) && col_ready_in;
  assign w_push      = w_complete && (r_state == ST_COLLECT) && (!w_full || w_pop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_mask[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_row_data;
        r_mem_mask[r_wr_ptr] <= r_mask;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  assign col_valid_out = (r_count != '0);
  assign col_data_out  = col_valid_out ? r_mem_data[r_rd_ptr] : '0;
  assign col_mask_out  = col_valid_out ? r_mem_mask[r_rd_ptr] : '0;

  // Done is raised on the edge that leaves the FIFO empty, so it is visible
  // in the first empty cycle after the final pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_misalign) r_proto_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_complete) r_proto_err <= 1'b1;
          if (ub_wr_row_count_valid_in) begin
            if (ub_wr_row_count_in != '0) begin
              r_remaining <= ub_wr_row_count_in;
              r_busy      <= 1'b1;
              r_state     <= ST_COLLECT;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (w_complete) begin
            if (w_full && !w_pop) r_overflow <= 1'b1;
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_complete) r_proto_err <= 1'b1;
          if (w_count_nxt == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign col_busy      = r_busy;
  assign col_done      = r_done;
  assign col_overflow  = r_overflow;
  assign col_proto_err = r_proto_err;

endmodule

// File: tb/tb_systolic_out_collector.sv
// Directed bench for systolic_out_collector: skewed row driver, scoreboard
// of expected aligned rows, flag and handshake checks, one summary line.
module tb_systolic_out_collector;
  logic        clk;
  logic        rst;
  logic [15:0] tb_d [4];
  logic        tb_v [4];
  logic [15:0] ub_rd_col_size_in;
  logic        ub_rd_col_size_valid_in;
  logic [15:0] ub_wr_row_count_in;
  logic        ub_wr_row_count_valid_in;
  logic [63:0] col_data_out;
  logic [3:0]  col_mask_out;
  logic        col_valid_out;
  logic        col_ready_in;
  logic        col_busy;
  logic        col_done;
  logic        col_overflow;
  logic        col_proto_err;

  systolic_out_collector #(.SYSTOLIC_ARRAY_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .sys_data_out_41          (tb_d[0]),
    .sys_data_out_42          (tb_d[1]),
    .sys_data_out_43          (tb_d[2]),
    .sys_data_out_44          (tb_d[3]),
    .sys_valid_out_41         (tb_v[0]),
    .sys_valid_out_42         (tb_v[1]),
    .sys_valid_out_43         (tb_v[2]),
    .sys_valid_out_44         (tb_v[3]),
    .ub_rd_col_size_in        (ub_rd_col_size_in),
    .ub_rd_col_size_valid_in  (ub_rd_col_size_valid_in),
    .ub_wr_row_count_in       (ub_wr_row_count_in),
    .ub_wr_row_count_valid_in (ub_wr_row_count_valid_in),
    .col_data_out             (col_data_out),
    .col_mask_out             (col_mask_out),
    .col_valid_out            (col_valid_out),
    .col_ready_in             (col_ready_in),
    .col_busy                 (col_busy),
    .col_done                 (col_done),
    .col_overflow             (col_overflow),
    .col_proto_err            (col_proto_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;
  int last_pop_cyc = -1;
  int first_valid_cyc = -1;
  int first_drive_cyc = -1;
  int done_cyc = -1;
  logic [63:0] exp_q [$];
  logic [3:0]  mask_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] col_val(input int r, input int j);
    return {8'(r), 8'(j)};
  endfunction

  function automatic logic [63:0] row_word(input int r, input logic [3:0] m);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) if (m[j]) w[16*j +: 16] = col_val(r, j + 1);
    return w;
  endfunction

  // scoreboard: every accepted head is compared against the expected queue
  always @(negedge clk) begin
    if (col_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (col_valid_out && col_ready_in) begin
      check("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("row_data", col_data_out, exp_q.pop_front());
        check("row_mask", 64'(col_mask_out), 64'(mask_q.pop_front()));
      end
      n_pops++;
      last_pop_cyc = cyc;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    mask_q.delete();
  endtask

  task automatic load_mask(input int size);
    ub_rd_col_size_in       = 16'(size);
    ub_rd_col_size_valid_in = 1'b1;
    tick();
    ub_rd_col_size_valid_in = 1'b0;
  endtask

  task automatic arm(input int n);
    ub_wr_row_count_in       = 16'(n);
    ub_wr_row_count_valid_in = 1'b1;
    tick();
    ub_wr_row_count_valid_in = 1'b0;
  endtask

  task automatic cfg(input int size, input int n);
    ub_rd_col_size_in        = 16'(size);
    ub_rd_col_size_valid_in  = 1'b1;
    ub_wr_row_count_in       = 16'(n);
    ub_wr_row_count_valid_in = 1'b1;
    tick();
    ub_rd_col_size_valid_in  = 1'b0;
    ub_wr_row_count_valid_in = 1'b0;
  endtask

  task automatic expect_row(input int r, input logic [3:0] m);
    exp_q.push_back(row_word(r, m));
    mask_q.push_back(m);
  endtask

  // Row i (value base+i) has column j valid at t = i*spacing + j; column 3 of
  // bad_row is one cycle late. Reset is asserted at t == rst_t and driving stops.
  task automatic drive_rows(input int n, input int base, input int spacing,
                            input logic [3:0] vmask, input int bad_row, input int rst_t);
    int tmax;
    tmax = (n - 1) * spacing + 4;
    for (int t = 0; t <= tmax; t++) begin
      for (int j = 0; j < 4; j++) begin
        tb_v[j] = 1'b0;
        tb_d[j] = '0;
        for (int r = 0; r < n; r++) begin
          if (vmask[j] && t == r * spacing + j + ((r == bad_row && j == 2) ? 1 : 0)) begin
            tb_v[j] = 1'b1;
            tb_d[j] = col_val(base + r, j + 1);
          end
        end
      end
      if (t == 0) first_drive_cyc = cyc;
      if (t == rst_t) rst = 1'b1;
      tick();
      if (t == rst_t) break;
    end
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tb_v[j] = 1'b0;
      tb_d[j] = '0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int found;
    found = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (col_done) begin
        found = 1;
        done_cyc = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(found), 64'd1);
    if (found != 0) check({tag, "_busy_at_done"}, 64'(col_busy), 64'd0);
    tick();
    if (found != 0) check({tag, "_done_one_cycle"}, 64'(col_done), 64'd0);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},     col_data_out, 64'd0);
    check({tag, "_mask"},     64'(col_mask_out), 64'd0);
    check({tag, "_valid"},    64'(col_valid_out), 64'd0);
    check({tag, "_busy"},     64'(col_busy), 64'd0);
    check({tag, "_done"},     64'(col_done), 64'd0);
    check({tag, "_overflow"}, 64'(col_overflow), 64'd0);
    check({tag, "_proto"},    64'(col_proto_err), 64'd0);
  endtask

  initial begin
    int pops0;
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tb_v[j] = 1'b0;
      tb_d[j] = '0;
    end
    ub_rd_col_size_in        = '0;
    ub_rd_col_size_valid_in  = 1'b0;
    ub_wr_row_count_in       = '0;
    ub_wr_row_count_valid_in = 1'b0;
    col_ready_in             = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // full-width tile, consumer always ready
    cfg(4, 4);
    check("t1_busy", 64'(col_busy), 64'd1);
    col_ready_in = 1'b1;
    for (int r = 1; r <= 4; r++) expect_row(r, 4'b1111);
    first_valid_cyc = -1;
    drive_rows(4, 1, 1, 4'b1111, -1, -1);
    check("t1_latency", 64'(first_valid_cyc - first_drive_cyc), 64'd5);
    wait_done("t1", 30);
    check("t1_done_after_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
    check("t1_overflow", 64'(col_overflow), 64'd0);
    check("t1_proto", 64'(col_proto_err), 64'd0);

    // two enabled columns, upper columns zero-filled
    do_reset();
    cfg(2, 2);
    col_ready_in = 1'b1;
    for (int r = 1; r <= 2; r++) expect_row(r, 4'b0011);
    drive_rows(2, 1, 1, 4'b0011, -1, -1);
    wait_done("t2", 30);
    check("t2_proto", 64'(col_proto_err), 64'd0);

    // overflow: 6 rows into a 4-deep FIFO with the consumer stalled
    do_reset();
    cfg(4, 6);
    col_ready_in = 1'b0;
    drive_rows(6, 1, 1, 4'b1111, -1, -1);
    tick();
    tick();
    check("t3_overflow", 64'(col_overflow), 64'd1);
    check("t3_valid", 64'(col_valid_out), 64'd1);
    check("t3_busy", 64'(col_busy), 64'd1);
    check("t3_hold_data_a", col_data_out, row_word(1, 4'b1111));
    tick();
    check("t3_hold_data_b", col_data_out, row_word(1, 4'b1111));
    check("t3_hold_mask", 64'(col_mask_out), 64'hF);
    for (int r = 1; r <= 4; r++) expect_row(r, 4'b1111);
    pops0 = n_pops;
    col_ready_in = 1'b1;
    wait_done("t3", 30);
    check("t3_pop_count", 64'(n_pops - pops0), 64'd4);
    check("t3_overflow_sticky", 64'(col_overflow), 64'd1);

    // misaligned first row is dropped; tile waits for a fourth good row
    do_reset();
    cfg(4, 4);
    col_ready_in = 1'b1;
    for (int r = 2; r <= 4; r++) expect_row(r, 4'b1111);
    drive_rows(4, 1, 2, 4'b1111, 0, -1);
    tick();
    tick();
    tick();
    check("t4_proto", 64'(col_proto_err), 64'd1);
    check("t4_busy", 64'(col_busy), 64'd1);
    check("t4_no_done", 64'(col_done), 64'd0);
    check("t4_rows_out", 64'(exp_q.size()), 64'd0);
    expect_row(9, 4'b1111);
    drive_rows(1, 9, 1, 4'b1111, -1, -1);
    wait_done("t4", 30);

    // complete row in IDLE, then a zero-row tile
    do_reset();
    load_mask(4);
    drive_rows(1, 7, 1, 4'b1111, -1, -1);
    tick();
    tick();
    check("t5_proto", 64'(col_proto_err), 64'd1);
    check("t5_valid", 64'(col_valid_out), 64'd0);
    arm(0);
    check("t5_done_pulse", 64'(col_done), 64'd1);
    check("t5_busy", 64'(col_busy), 64'd0);
    tick();
    check("t5_done_low", 64'(col_done), 64'd0);
    check("t5_fifo_empty", 64'(col_valid_out), 64'd0);

    // reset with two rows buffered and two still in the delay lines
    do_reset();
    cfg(4, 4);
    col_ready_in = 1'b0;
    drive_rows(4, 1, 1, 4'b1111, -1, 6);
    check_reset_outputs("t6_reset");
    load_mask(4);
    for (int k = 0; k < 6; k++) tick();
    check("t6_no_stale_row", 64'(col_proto_err), 64'd0);
    check("t6_fifo_empty", 64'(col_valid_out), 64'd0);
    check("t6_idle", 64'(col_busy), 64'd0);
    cfg(4, 1);
    col_ready_in = 1'b1;
    expect_row(5, 4'b1111);
    drive_rows(1, 5, 1, 4'b1111, -1, -1);
    wait_done("t6", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
